serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//   Bit-serial two's-complement adder/subtractor. It processes one bit per clock through a full adder built from two half-adder cells and a carry flip-flop.
//   It trades latency for area in the Hack datapath.
//   Upstream: register file / instruction decode supplies operands over a valid/ready handshake.
//   Downstream: ALU result mux / D-register consumes sum and flags over a valid/ready handshake.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; legal range >= 2
// PORTS
//   clk        in   1      single clock, rising-edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands and op presented
//   in_ready   out  1      block can accept operands
//   op_sub     in   1      0: a+b ; 1: a-b (sampled on accept)
//   a          in   WIDTH  operand A (sampled on accept)
//   b          in   WIDTH  operand B (sampled on accept)
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result
//   cout       out  1      carry out; for sub, 1 = no borrow
//   ovf        out  1      signed overflow
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0.
//     Reset also clears sum=0, cout=0, ovf=0, and all internal shift registers, carry and counter.
//   FSM states: IDLE -> RUN -> DONE -> IDLE. No other states; any illegal encoding returns to IDLE.
//   in_ready = (state==IDLE); out_valid = (state==DONE). Both are pure state decodes.
//   IDLE: accept on in_valid & in_ready. On accept:
//     A_sr <= a; B_sr <= op_sub ? ~b : b; carry <= op_sub; cnt <= 0; go to RUN.
//   RUN, each edge:
//     - Full adder on (A_sr[0], B_sr[0], carry).
//     - Sum bit shifts into sum_sr MSB; A_sr and B_sr shift right; carry <= full-adder carry; cnt++.
//     - On the edge with cnt==WIDTH-1: carry into the MSB is saved as c_msb, then go to DONE.
//   DONE: sum = sum_sr, cout = carry, ovf = carry ^ c_msb.
//     Outputs are held stable for as long as out_valid=1 and out_ready=0.
//     On out_valid & out_ready, go to IDLE. in_ready rises the next cycle; there is no overlap.
//   Latency: out_valid is high exactly WIDTH clock edges after the accepting edge.
//     Minimum initiation interval is WIDTH+2 cycles.
//   sum, cout and ovf are meaningful only while out_valid=1.
//     During RUN, sum shows the partially shifted register.
//   in_valid while state!=IDLE is ignored (in_ready=0); operands are not queued.
//   Width rules: cnt is $clog2(WIDTH) bits. Results wrap modulo 2^WIDTH; the carry beyond WIDTH appears only on cout.
//   Reset mid-RUN or mid-DONE aborts the operation: no out_valid pulse, and the result is discarded.
//   Simultaneous out_ready and in_valid in DONE: only the output handshake completes.
//     The new operands are accepted no earlier than the following IDLE cycle.
// STRUCTURE
//   Package serial_adder_pkg:
//     - typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t
//     - localparam SA_DEFAULT_WIDTH = 16
//   Sub-module full_adder (a, b, cin -> sum, cout):
//     - two half_adder instances plus an OR of their carries
//     - instantiated once for the serial bit slice
//   Top level holds the FSM, bit counter, A/B/sum shift registers, carry and c_msb flops.
// TESTING (WIDTH=16; each case checks in_ready/out_valid timing)
//   1. add 0x1234+0x4321 -> sum=0x5555 cout=0 ovf=0; out_valid exactly 16 edges after accept
//   2. add 0xFFFF+0x0001 -> sum=0x0000 cout=1 ovf=0; add 0x7FFF+0x0001 -> sum=0x8000 cout=0 ovf=1
//   3. sub 0x0005-0x0007 -> sum=0xFFFE cout=0 ovf=0; sub 0x8000-0x0001 -> sum=0x7FFF cout=1 ovf=1
//   4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, sum/cout/ovf stable.
//      Meanwhile in_valid=1 is held with new operands -> not accepted; in_ready=1 only after release.
//   5. rst_n low on 8th RUN cycle -> all outputs 0 asynchronously; after release, in_ready=1.
//      The aborted result never produces out_valid.
//   6. Back-to-back: two ops with in_valid held high -> accepts are spaced WIDTH+2 cycles.
//      Both results are correct vs. a reference model; then run 1000 random ops with random op_sub and random out_ready.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

   localparam int SA_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Full adder built from two half adders; one instance forms the serial bit slice.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s0, c0, c1;

   half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
   half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

   assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder_half_adder.sv
// Half-adder cell: the building block of the serial full-adder slice.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder/subtractor, one bit per clock, valid/ready on both sides.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);

   sa_state_t        state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
   logic [CNT_W-1:0] cnt;
   logic             carry, c_msb;
   logic             fa_sum, fa_cout;
   logic             accept, last_bit;

   assign accept   = in_valid & in_ready;
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last_bit)  state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
   // NOTE: shift registers are reset too, so an aborted operation leaves no stale result visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         c_msb  <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= op_sub ? ~b : b;
         carry <= op_sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
         carry  <= fa_cout;
         cnt    <= cnt + CNT_W'(1);
         if (last_bit) c_msb <= carry;
      end
   end

   // Signed overflow: carry into the MSB differs from carry out of it.
   assign sum  = sum_sr;
   assign cout = carry;
   assign ovf  = carry ^ c_msb;

endmodule
